// File: rtl/tt_ram_pkg.sv
// Shared constants, FSM state type and the address range helper for the
// 48-byte RAM arbiter.
package tt_ram_pkg;

    localparam int ADDR_BITS = 6;
    localparam int NUM_BYTES = 48;
    localparam int DATA_BITS = 8;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } arb_state_e;

    // Only the low NUM_BYTES addresses of the address space are backed by RAM.
    function automatic logic addr_in_range(input logic [ADDR_BITS-1:0] addr);
        return (addr < ADDR_BITS'(NUM_BYTES));
    endfunction

endpackage

// File: rtl/tt_ram_sp.sv
// Single-port synchronous byte RAM with a registered read port.
// The array is deliberately not reset; the arbiter zeroes it by sequencing.
module tt_ram_sp
    import tt_ram_pkg::*;
(
    input  logic                 clk,
    input  logic                 en_i,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [DATA_BITS-1:0] wdata_i,
    output logic [DATA_BITS-1:0] rdata_o
);

    logic [DATA_BITS-1:0] mem_q [NUM_BYTES];
    logic [DATA_BITS-1:0] rdata_q;

    // Write the array or capture read data for the enabled access.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end else begin
            rdata_q <= rdata_q;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tt_ram_arbiter.sv
// Two-port round-robin arbiter and clear sequencer in front of the byte RAM.
// After reset (or on clear_start) every byte is written to zero, then one
// request per cycle is granted; each handshake gets a response one cycle later.
module tt_ram_arbiter
    import tt_ram_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_we,
    input  logic [2*ADDR_BITS-1:0] req_addr,
    input  logic [2*DATA_BITS-1:0] req_wdata,
    output logic [1:0]             rsp_valid,
    output logic [DATA_BITS-1:0]   rsp_rdata,
    output logic                   rsp_err,
    input  logic                   clear_start,
    output logic                   busy
);

    arb_state_e           state_q, state_d;
    logic [ADDR_BITS-1:0] clr_cnt_q, clr_cnt_d;
    logic                 last_grant_q;
    logic [1:0]           rsp_valid_q;
    logic                 rsp_err_q;
    logic                 rsp_zero_q;

    logic                 grant_any_s;
    logic                 grant_port_s;
    logic                 accept_s;
    logic [ADDR_BITS-1:0] sel_addr_s;
    logic [DATA_BITS-1:0] sel_wdata_s;
    logic                 sel_we_s;
    logic                 sel_in_range_s;

    logic                 ram_en_s;
    logic                 ram_we_s;
    logic [ADDR_BITS-1:0] ram_addr_s;
    logic [DATA_BITS-1:0] ram_wdata_s;
    logic [DATA_BITS-1:0] ram_rdata_s;

    // Pick a port: a lone requester wins, a tie goes to the port not granted last.
    always_comb begin
        grant_any_s  = 1'b0;
        grant_port_s = 1'b0;
        case (req_valid)
            2'b01: begin
                grant_any_s  = 1'b1;
                grant_port_s = 1'b0;
            end
            2'b10: begin
                grant_any_s  = 1'b1;
                grant_port_s = 1'b1;
            end
            2'b11: begin
                grant_any_s  = 1'b1;
                grant_port_s = ~last_grant_q;
            end
            default: begin
                grant_any_s  = 1'b0;
                grant_port_s = 1'b0;
            end
        endcase
    end

    // A clear request in IDLE pre-empts any grant in the same cycle.
    assign accept_s  = (state_q == ST_IDLE) && !clear_start && grant_any_s;
    assign req_ready = accept_s ? (grant_port_s ? 2'b10 : 2'b01) : 2'b00;

    assign sel_addr_s     = grant_port_s ? req_addr[2*ADDR_BITS-1:ADDR_BITS]
                                         : req_addr[ADDR_BITS-1:0];
    assign sel_wdata_s    = grant_port_s ? req_wdata[2*DATA_BITS-1:DATA_BITS]
                                         : req_wdata[DATA_BITS-1:0];
    assign sel_we_s       = grant_port_s ? req_we[1] : req_we[0];
    assign sel_in_range_s = addr_in_range(sel_addr_s);

    // Next state and clear address counter.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q == ADDR_BITS'(NUM_BYTES - 1)) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = {ADDR_BITS{1'b0}};
                end else begin
                    clr_cnt_d = clr_cnt_q + {{(ADDR_BITS-1){1'b0}}, 1'b1};
                end
            end
            ST_IDLE: begin
                if (clear_start) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = {ADDR_BITS{1'b0}};
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = {ADDR_BITS{1'b0}};
            end
        endcase
    end

    // Steer the RAM port: clear writes while clearing, else the granted in-range op.
    always_comb begin
        ram_en_s    = 1'b0;
        ram_we_s    = 1'b0;
        ram_addr_s  = sel_addr_s;
        ram_wdata_s = sel_wdata_s;
        if (state_q == ST_CLEAR) begin
            ram_en_s    = 1'b1;
            ram_we_s    = 1'b1;
            ram_addr_s  = clr_cnt_q;
            ram_wdata_s = {DATA_BITS{1'b0}};
        end else if (accept_s && sel_in_range_s) begin
            ram_en_s = 1'b1;
            ram_we_s = sel_we_s;
        end else begin
            ram_en_s = 1'b0;
            ram_we_s = 1'b0;
        end
    end

    // FSM, clear counter and round-robin history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CLEAR;
            clr_cnt_q    <= {ADDR_BITS{1'b0}};
            last_grant_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            if (accept_s) begin
                last_grant_q <= grant_port_s;
            end else begin
                last_grant_q <= last_grant_q;
            end
        end
    end

    // Response pipeline: which port answered, error flag, and whether RAM data is returned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 1'b0;
            rsp_zero_q  <= 1'b1;
        end else begin
            rsp_valid_q <= req_valid & req_ready;
            rsp_err_q   <= accept_s && !sel_in_range_s;
            rsp_zero_q  <= !(accept_s && sel_in_range_s && !sel_we_s);
        end
    end

    tt_ram_sp u_ram (
        .clk     (clk),
        .en_i    (ram_en_s),
        .we_i    (ram_we_s),
        .addr_i  (ram_addr_s),
        .wdata_i (ram_wdata_s),
        .rdata_o (ram_rdata_s)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_zero_q ? {DATA_BITS{1'b0}} : ram_rdata_s;
    assign busy      = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_tt_ram_arbiter.sv
// Self-checking bench for tt_ram_arbiter: directed scenarios plus random
// traffic, all compared against a behavioural model of the RAM and arbiter.
module tb_tt_ram_arbiter;

    localparam int NB = 48;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [11:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        clear_start;
    logic        busy;

    tt_ram_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .clear_start (clear_start),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [7:0] mdl_mem [NB];
    int         mdl_clear_left;
    int         mdl_last;
    logic [1:0] exp_rv;
    logic [7:0] exp_rd;
    logic       exp_re;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        mdl_clear_left = NB;
        mdl_last       = 1;
        exp_rv         = 2'b00;
        exp_rd         = 8'h00;
        exp_re         = 1'b0;
        for (int i = 0; i < NB; i++) mdl_mem[i] = 8'h00;
    endtask

    // One clock cycle; entered and left 1 time unit after a rising edge.
    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [5:0] a0, input logic [5:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input logic clr);
        int         g;
        int         a;
        logic       w;
        logic [7:0] d;
        logic [1:0] er;
        check_val("rsp_valid", {30'd0, rsp_valid}, {30'd0, exp_rv});
        if (exp_rv != 2'b00) begin
            check_val("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, exp_rd});
            check_val("rsp_err", {31'd0, rsp_err}, {31'd0, exp_re});
        end
        req_valid   = v;
        req_we      = we;
        req_addr    = {a1, a0};
        req_wdata   = {d1, d0};
        clear_start = clr;
        #2;
        check_val("busy", {31'd0, busy}, (mdl_clear_left > 0) ? 32'd1 : 32'd0);
        g = -1;
        if (mdl_clear_left > 0) begin
            mdl_clear_left--;
        end else if (clr) begin
            mdl_clear_left = NB;
            for (int i = 0; i < NB; i++) mdl_mem[i] = 8'h00;
        end else if (v == 2'b01) begin
            g = 0;
        end else if (v == 2'b10) begin
            g = 1;
        end else if (v == 2'b11) begin
            g = (mdl_last == 0) ? 1 : 0;
        end
        er = (g == 0) ? 2'b01 : ((g == 1) ? 2'b10 : 2'b00);
        check_val("req_ready", {30'd0, req_ready}, {30'd0, er});
        exp_rv = er;
        exp_rd = 8'h00;
        exp_re = 1'b0;
        if (g >= 0) begin
            a = (g == 1) ? int'(a1) : int'(a0);
            w = we[g];
            d = (g == 1) ? d1 : d0;
            mdl_last = g;
            if (a >= NB) begin
                exp_re = 1'b1;
            end else if (w) begin
                mdl_mem[a] = d;
            end else begin
                exp_rd = mdl_mem[a];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(2'b00, 2'b00, 6'd0, 6'd0, 8'h00, 8'h00, 1'b0);
    endtask

    // Reset pulse of two cycles; entered and left 1 time unit after a rising edge.
    task automatic do_reset();
        req_valid   = 2'b00;
        req_we      = 2'b00;
        req_addr    = 12'd0;
        req_wdata   = 16'd0;
        clear_start = 1'b0;
        rst_n       = 1'b0;
        #1;
        check_val("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check_val("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        check_val("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd1);
        check_val("rst_req_ready", {30'd0, req_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = 2'b00;
        req_we      = 2'b00;
        req_addr    = 12'd0;
        req_wdata   = 16'd0;
        clear_start = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Clear after reset, then read back every address with ports alternating.
        drive(2'b01, 2'b00, 6'd0, 6'd0, 8'h00, 8'h00, 1'b0);  // ignored while clearing
        idle(NB - 1);
        for (int i = 0; i < NB; i++) begin
            if (i % 2 == 0) drive(2'b01, 2'b00, 6'(i), 6'd0, 8'h00, 8'h00, 1'b0);
            else            drive(2'b10, 2'b00, 6'd0, 6'(i), 8'h00, 8'h00, 1'b0);
        end

        // Write on port 0 followed immediately by a read of the same byte on port 1.
        drive(2'b01, 2'b01, 6'd7, 6'd0, 8'hA5, 8'h00, 1'b0);
        drive(2'b10, 2'b00, 6'd0, 6'd7, 8'h00, 8'h00, 1'b0);
        idle(1);

        // Continuous contention: grants alternate.
        for (int i = 0; i < 6; i++) drive(2'b11, 2'b00, 6'd7, 6'(i), 8'h00, 8'h00, 1'b0);
        idle(1);

        // Out-of-range write and read, then the aliased address is untouched.
        drive(2'b10, 2'b10, 6'd0, 6'd50, 8'h00, 8'h3C, 1'b0);
        drive(2'b10, 2'b00, 6'd0, 6'd50, 8'h00, 8'h00, 1'b0);
        drive(2'b01, 2'b00, 6'd2, 6'd0, 8'h00, 8'h00, 1'b0);
        idle(1);

        // Clear on demand wins over a pending request and wipes prior data.
        drive(2'b01, 2'b01, 6'd47, 6'd0, 8'hFF, 8'h00, 1'b0);
        drive(2'b01, 2'b00, 6'd47, 6'd0, 8'h00, 8'h00, 1'b1);
        drive(2'b01, 2'b00, 6'd47, 6'd0, 8'h00, 8'h00, 1'b1);  // clear_start while clearing
        idle(NB - 1);
        drive(2'b01, 2'b00, 6'd47, 6'd0, 8'h00, 8'h00, 1'b0);
        idle(1);

        // Random traffic with occasional clears.
        for (int i = 0; i < 600; i++) begin
            drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  6'($urandom_range(0, 55)), 6'($urandom_range(0, 55)),
                  8'($urandom), 8'($urandom),
                  ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
        end

        // Reset in the middle of traffic with a response pending.
        drive(2'b01, 2'b00, 6'd3, 6'd0, 8'h00, 8'h00, 1'b0);
        do_reset();
        idle(20);
        // Reset again at clear cycle 20: clear restarts for the full length.
        do_reset();
        idle(NB);
        drive(2'b10, 2'b00, 6'd0, 6'd47, 8'h00, 8'h00, 1'b0);
        idle(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
